fu_mul_pipe: RTL and testbench

FU_MUL_PIPE -- requirements
Module: fu_mul_pipe

---
 rtl/fu_mul_pipe.sv | 94 +++++++++
 tb/tb_fu_mul_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fu_mul_pipe.sv
// Pipelined integer multiplier covering MUL/MULH/MULHSU/MULHU, with tag tracking,
// output back-pressure (the whole pipe freezes on stall) and flush.
module fu_mul_pipe #(
  parameter int XLEN  = 32,
  parameter int LAT   = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] FU_ID,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic             flush,
  output logic [XLEN-1:0]  res,
  output logic [TAG_W-1:0] finish,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy
);

  // Index 0 holds raw operands; indices 1..LAT hold the selected result, and LAT is the output stage.
  logic [LAT:0]      vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [0:LAT];
  logic [TAG_W-1:0]  tag_d [0:LAT];
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   dat_q [1:LAT];
  logic [XLEN-1:0]   dat_d [1:LAT];

  logic              stall;
  logic              signA, signB;
  logic [2*XLEN-1:0] aWide, bWide, prod;
  logic [XLEN-1:0]   mulRes;

  assign stall     = vld_q[LAT] & ~res_ack;
  assign ready     = ~stall & ~flush;
  assign res_valid = vld_q[LAT];
  assign res       = vld_q[LAT] ? dat_q[LAT] : '0;
  assign finish    = vld_q[LAT] ? tag_q[LAT] : '0;
  assign busy      = |vld_q;

  // Extending both operands to 2*XLEN makes a plain modular multiply exact for every sign mix.
  always_comb begin
    signA  = (op_q != 2'b11);
    signB  = (op_q == 2'b01);
    aWide  = {{XLEN{signA & a_q[XLEN-1]}}, a_q};
    bWide  = {{XLEN{signB & b_q[XLEN-1]}}, b_q};
    prod   = aWide * bWide;
    mulRes = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall) begin
      vld_d    = {vld_q[LAT-1:0], EN};
      tag_d[0] = FU_ID;
      op_d     = op;
      a_d      = A;
      b_d      = B;
      for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
      dat_d[1] = mulRes;
      for (int i = 2; i <= LAT; i++) dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
      for (int i = 1; i <= LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      tag_q <= tag_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Randomized scoreboard bench for fu_mul_pipe: an arithmetic reference model predicts
// each result, its tag and the cycle it must appear, including stalls, flush and reset.
module tb_fu_mul_pipe;
  localparam int XLEN  = 32;
  localparam int LAT   = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             EN = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [TAG_W-1:0] FU_ID = '0;
  logic [XLEN-1:0]  A = '0;
  logic [XLEN-1:0]  B = '0;
  logic             flush = 1'b0;
  logic             res_ack = 1'b1;
  logic             ready, res_valid, busy;
  logic [XLEN-1:0]  res;
  logic [TAG_W-1:0] finish;

  fu_mul_pipe #(.XLEN(XLEN), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .EN(EN), .ready(ready), .op(op), .FU_ID(FU_ID),
    .A(A), .B(B), .flush(flush), .res(res), .finish(finish),
    .res_valid(res_valid), .res_ack(res_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               iss;
    int               st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   stallCnt = 0;
  int   testsRun = 0;
  int   failCnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the textbook RISC-V M-extension definitions using 64-bit arithmetic.
  function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (o)
      2'b00:   p = ua * ub;
      2'b01:   p = longint'(sa * sb);
      2'b10:   p = longint'(sa * longint'(ub));
      default: p = ua * ub;
    endcase
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: predicts visibility from issue time plus accumulated stall cycles.
  always begin
    bit expValid, expStall, expReady;
    @(negedge clk or posedge rst);
    if (rst) begin
      #1;
      q.delete();
      checkOutput("rst_res_valid", XLEN'(res_valid), '0);
      checkOutput("rst_res", res, '0);
      checkOutput("rst_finish", XLEN'(finish), '0);
      checkOutput("rst_busy", XLEN'(busy), '0);
      checkOutput("rst_ready", XLEN'(ready), XLEN'(1));
    end else begin
      expValid = 1'b0;
      if (q.size() > 0)
        expValid = (cyc - q[0].iss - (stallCnt - q[0].st)) >= LAT + 1;
      expStall = expValid && !res_ack;
      expReady = !expStall && !flush;
      checkOutput("res_valid", XLEN'(res_valid), XLEN'(expValid));
      checkOutput("ready", XLEN'(ready), XLEN'(expReady));
      checkOutput("busy", XLEN'(busy), XLEN'(q.size() > 0));
      if (expValid) begin
        checkOutput("res", res, q[0].res);
        checkOutput("finish", XLEN'(finish), XLEN'(q[0].tag));
      end else begin
        checkOutput("idle_res", res, '0);
        checkOutput("idle_finish", XLEN'(finish), '0);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (expStall) stallCnt++;
        if (expValid && res_ack) void'(q.pop_front());
        if (EN && expReady) q.push_back('{model(op, A, B), FU_ID, cyc, stallCnt});
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [1:0] o, input logic [TAG_W-1:0] tag,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic ack, input logic fl);
    EN = en; op = o; FU_ID = tag; A = a; B = b; res_ack = ack; flush = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // Single MUL with latency, then the three high-half flavours.
    applyStimulus(1'b1, 2'b00, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle(LAT + 2);
    applyStimulus(1'b1, 2'b01, 4'd5, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b11, 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle(LAT + 2);

    // Eight back-to-back issues, tags 1..8.
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), TAG_W'(i), randOperand(), randOperand(),
                    1'b1, 1'b0);
    idle(LAT + 2);

    // Back-pressure: consumer refuses for five cycles while issue continues.
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), TAG_W'($urandom_range(1, 15)),
                    randOperand(), randOperand(), !(i >= 4 && i <= 8), 1'b0);
    idle(LAT + 4);

    // Flush with a concurrent issue that must be dropped.
    for (int i = 1; i <= 3; i++)
      applyStimulus(1'b1, 2'b00, TAG_W'(i + 8), randOperand(), randOperand(), 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    idle(LAT + 2);

    // Asynchronous reset between edges with two ops in flight.
    applyStimulus(1'b1, 2'b11, 4'd13, randOperand(), randOperand(), 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'd14, randOperand(), randOperand(), 1'b1, 1'b0);
    EN = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    idle(LAT + 2);
    applyStimulus(1'b1, 2'b00, 4'd15, 32'd12345, 32'd678, 1'b1, 1'b0);
    idle(LAT + 2);

    // Random traffic with random back-pressure and occasional flush.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                    TAG_W'($urandom_range(1, 15)), randOperand(), randOperand(),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    idle(LAT + 10);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end
endmodule
